// File: rtl/stat_display_if.sv
// Statistics-to-display bus: five counter sources, button/freeze controls and
// the multiplexed seven-segment outputs.
interface stat_display_if;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_num;
  logic [31:0] condi_num;
  logic [31:0] condi_suc_num;
  logic [31:0] syscall_out;
  logic        btn_next;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  mode;

  modport master (
    output total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out,
    output btn_next, freeze,
    input  an, seg, dp, mode
  );

  modport slave (
    input  total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out,
    input  btn_next, freeze,
    output an, seg, dp, mode
  );
endinterface

// File: rtl/stat_display.sv
// Scans one of five 32-bit statistics onto an 8-digit multiplexed seven-segment
// display; a debounced button selects the source, one snapshot per frame.
module stat_display #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 200000
) (
  input logic          clk,
  input logic          rst,
  stat_display_if.slave bus
);
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

  logic            btn_meta, btn_s, btn_stable, btn_prev, adv;
  logic [DB_W-1:0] db_cnt;
  logic [DIV_W-1:0] div;
  logic [2:0]      idx, mode_q;
  logic [31:0]     shadow, sel, sh_shift;
  logic            wrap, frame_end;
  logic [7:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'h0: seg_enc = 7'h40;  4'h1: seg_enc = 7'h79;
      4'h2: seg_enc = 7'h24;  4'h3: seg_enc = 7'h30;
      4'h4: seg_enc = 7'h19;  4'h5: seg_enc = 7'h12;
      4'h6: seg_enc = 7'h02;  4'h7: seg_enc = 7'h78;
      4'h8: seg_enc = 7'h00;  4'h9: seg_enc = 7'h10;
      4'hA: seg_enc = 7'h08;  4'hB: seg_enc = 7'h03;
      4'hC: seg_enc = 7'h46;  4'hD: seg_enc = 7'h21;
      4'hE: seg_enc = 7'h06;  default: seg_enc = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta   <= 1'b0;
      btn_s      <= 1'b0;
      btn_stable <= 1'b0;
      btn_prev   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      btn_meta <= bus.btn_next;
      btn_s    <= btn_meta;
      btn_prev <= btn_stable;
      // Any return to the accepted level restarts the stability count.
      if (btn_s == btn_stable)
        db_cnt <= '0;
      else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        btn_stable <= btn_s;
        db_cnt     <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  end

  assign adv = btn_stable & ~btn_prev;

  always_ff @(posedge clk) begin
    if (rst)      mode_q <= 3'd0;
    else if (adv) mode_q <= (mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1;
  end

  assign wrap      = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = wrap & (idx == 3'd7);

  always_comb begin
    sel = 32'h0;
    case (mode_q)
      3'd0:    sel = bus.total_cycles;
      3'd1:    sel = bus.uncondi_num;
      3'd2:    sel = bus.condi_num;
      3'd3:    sel = bus.condi_suc_num;
      3'd4:    sel = bus.syscall_out;
      default: sel = 32'h0;
    endcase
  end

  // The snapshot uses the registered mode, so an advance landing on the
  // boundary cycle still loads the previous selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      idx    <= 3'd0;
      shadow <= 32'h0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) idx <= idx + 3'd1;
      if (frame_end && !bus.freeze) shadow <= sel;
    end
  end

  assign sh_shift = shadow >> {idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 8'hFE;
      seg_q <= 7'h40;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(8'b1 << idx);
      seg_q <= seg_enc(sh_shift[3:0]);
      dp_q  <= ~((idx == 3'd0) & bus.freeze);
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.mode = mode_q;
endmodule

// File: doc/stat_display.md
# stat_display

Scans the CPU performance counters and the syscall output register onto an 8-digit, common-anode, multiplexed seven-segment display.
- The block sits directly downstream of the statistics block and consumes its five 32-bit outputs.
- A debounced push-button cycles through the five values.
- The selected value is shown as 8 hex digits, snapshotted once per scan frame to avoid tearing.

## Interface
- `SCAN_DIV`, default 100000: clk cycles each digit is lit; minimum 2.
- `DEBOUNCE`, default 200000: consecutive stable cycles required to accept a button level; minimum 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `total_cycles` in 32: mode 0 source.
- `uncondi_num` in 32: mode 1 source.
- `condi_num` in 32: mode 2 source.
- `condi_suc_num` in 32: mode 3 source.
- `syscall_out` in 32: mode 4 source.
- `btn_next` in 1: raw, asynchronous push-button, active-high.
- `freeze` in 1: when high, the frame snapshot is held.
- `an` out 8: digit enables, active-low; `an[i]` lights digit i, with digit 0 the rightmost (least significant nibble).
- `seg` out 7: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: decimal point, active-low.
- `mode` out 3: current selection, 0–4.

## Operation
- **Synchronizer:** `btn_next` passes through a 2-flop synchronizer giving `btn_s`.
- **Debounce:**
  - State: `btn_stable` (reset 0) and `db_cnt` (reset 0).
  - If `btn_s == btn_stable`, `db_cnt <= 0`.
  - Otherwise `db_cnt` increments. On the cycle `db_cnt == DEBOUNCE-1`, `btn_stable <= btn_s` and `db_cnt <= 0`.
  - A glitch shorter than `DEBOUNCE` cycles is ignored.
- **Mode:**
  - A rising edge of `btn_stable` produces a single-cycle pulse `adv`.
  - On `adv`, `mode` advances 0→1→2→3→4→0. Values 5–7 are never reached.
  - Falling edges have no effect.
- **Scan divider:**
  - `div` counts 0..`SCAN_DIV`-1 and wraps.
  - On the wrap cycle (`div == SCAN_DIV-1`), `idx` (3-bit, reset 0) increments modulo 8.
- **Snapshot:**
  - `shadow` (32-bit, reset 0) loads the mode-selected input on the cycle `idx` wraps 7→0 (frame boundary), unless `freeze == 1`.
  - A mode change mid-frame does not alter `shadow`. The new value appears at the next frame boundary.
  - `mode` itself updates immediately.
- **Digit decode:** digit value = `shadow[4*idx+3 : 4*idx]`. `seg` encodings, in hex, for 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- **Decimal point:** `dp` = 0 (lit) only when `idx == 0` and `freeze == 1`; otherwise 1.
- **Outputs:** `an`, `seg` and `dp` are registered. `an = ~(8'b1 << idx)`; exactly one bit is low at all times after reset.

## Timing
- **Reset values:** `mode`=0, `idx`=0, `div`=0, `shadow`=0, `btn_stable`=0, `db_cnt`=0, `an`=8'hFE, `seg`=7'h40, `dp`=1.
- **Output latency:** `an`/`seg`/`dp` reflect `idx`/`shadow`/`freeze` with 1-cycle latency.
- **Digit dwell:** each digit stays lit for exactly `SCAN_DIV` cycles. A frame is 8×`SCAN_DIV` cycles.
- **Button to mode:** a clean press changes `mode` in 2 (sync) + `DEBOUNCE` + 1 (edge) cycles after `btn_next` rises.
- **Simultaneous events:**
  - If a frame boundary and `adv` coincide, `shadow` loads using the old `mode`.
  - `freeze` is sampled on the boundary cycle itself.
- **`rst` mid-operation:** all state returns to reset values on the next edge; `mode` returns to 0.
- **Input stability:** inputs are assumed stable within `clk`; only `btn_next` is asynchronous.

## Test plan
Use `SCAN_DIV=4`, `DEBOUNCE=3`.
1. **Reset and first frame:** reset, `total_cycles`=32'h1234ABCD, wait one frame (32 cycles).
   - Next frame: `an` steps FE, FD, FB, … 7F every 4 cycles.
   - `seg` shows D, C, B, A, 4, 3, 2, 1 (21, 46, 03, 08, 19, 30, 24, 79).
2. **Mode cycling:** five clean presses (each held 10 cycles).
   - `mode` goes 1, 2, 3, 4, 0.
   - In mode 4 with `syscall_out`=32'h0000000F, the next frame shows digit 0 = 0E and digits 1–7 = 40.
3. **Bounce rejection:** `btn_next` pulses high for 2 cycles, low 2, high 2.
   - `mode` is unchanged.
   - A subsequent 6-cycle hold advances `mode` exactly once.
4. **Freeze:**
   - Set `freeze`=1 mid-frame.
   - Change `total_cycles` to 32'hFFFFFFFF.
   - Display keeps the old value over 3 frames, with `dp`=0 only while `an`=FE.
   - Release `freeze`: the next frame shows all digits 0E.
5. **Mid-frame mode change and boundary coincidence:**
   - A mode change at `idx`=3 leaves the displayed digits from the old value until the frame boundary.
   - If `adv` lands on the boundary cycle, that frame loads the old mode's value.
6. **Reset mid-scan:** assert `rst` at `idx`=5, `mode`=3.
   - Next cycle: `mode`=0, `an`=FE, `seg`=40, `dp`=1.
